data_mem_sb: RTL and testbench



---
 rtl/data_mem_sb.sv | 130 +++++++++++++
 tb/tb_data_mem_sb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_sb.sv
// RV32I data memory with a one-entry byte-enabled store buffer,
// load forwarding, misaligned-access rejection and an LED MMIO register.
module data_mem_sb #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] LED_ADDR  = 32'h2000,
    parameter int          LED_W     = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             memwrite,
    input  logic             memread,
    input  logic [3:0]       sign_mask,
    output logic [31:0]      read_data,
    output logic [LED_W-1:0] led,
    output logic             clk_stall,
    output logic             misaligned
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} sb_state_t;

    sb_state_t        state, state_n;
    logic             sb_valid;
    logic [AW-1:0]    sb_idx;
    logic [3:0]       sb_be;
    logic [31:0]      sb_data;
    logic [31:0]      mem [DEPTH];
    logic [LED_W-1:0] led_reg;

    logic [AW-1:0] idx;
    logic          is_byte, is_half, is_word, is_led, mis;
    logic          stall, cap, led_we, load_go, drain, sext;
    logic [3:0]    be_n;
    logic [31:0]   data_n, fwd, led_word, ld_val;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;

    assign idx      = addr[AW+1:2];
    assign sb_valid = (state == FULL);
    assign led      = led_reg;
    assign clk_stall = stall;

    always_comb begin
        is_byte = (sign_mask[2:0] == 3'b001);
        is_half = (sign_mask[2:0] == 3'b011);
        is_word = ~is_byte & ~is_half;
        is_led  = (addr == LED_ADDR);
        mis     = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        stall   = memread & memwrite & sb_valid;
        cap     = memwrite & ~stall & ~mis & ~is_led;
        led_we  = memwrite & ~stall & ~mis & is_led;
        load_go = memread & ~stall;
        // a pending store dies with reset rather than landing in the array
        drain   = sb_valid & (~memread | stall) & ~reset;
    end

    always_comb begin
        be_n   = 4'b1111;
        data_n = write_data;
        if (is_byte) begin
            be_n   = 4'b0001 << addr[1:0];
            data_n = {4{write_data[7:0]}};
        end else if (is_half) begin
            be_n   = addr[1] ? 4'b1100 : 4'b0011;
            data_n = {2{write_data[15:0]}};
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            EMPTY: if (cap) state_n = FULL;
            FULL:  if (drain && !cap) state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            sb_idx  <= idx;
            sb_be   <= be_n;
            sb_data <= data_n;
        end
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int i = 0; i < 4; i++)
                if (sb_be[i]) mem[sb_idx][8*i +: 8] <= sb_data[8*i +: 8];
        end
    end

    always_comb begin
        led_word = '0;
        led_word[LED_W-1:0] = led_reg;
        fwd = mem[idx];
        for (int i = 0; i < 4; i++)
            if (sb_valid && sb_idx == idx && sb_be[i])
                fwd[8*i +: 8] = sb_data[8*i +: 8];
        if (is_led) fwd = led_word;
    end

    always_comb begin
        sext   = sign_mask[3] & ~is_led;
        ld_b   = fwd[{addr[1:0], 3'b000} +: 8];
        ld_h   = addr[1] ? fwd[31:16] : fwd[15:0];
        ld_val = fwd;
        if (is_byte)      ld_val = {{24{sext & ld_b[7]}}, ld_b};
        else if (is_half) ld_val = {{16{sext & ld_h[15]}}, ld_h};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data  <= '0;
            misaligned <= 1'b0;
            led_reg    <= '0;
        end else begin
            if (load_go) read_data <= mis ? 32'h0 : ld_val;
            misaligned <= ~stall & (memread | memwrite) & mis;
            if (led_we) led_reg <= write_data[LED_W-1:0];
        end
    end
endmodule

// File: tb/tb_data_mem_sb.sv
// Scoreboard bench for data_mem_sb: ideal flat-memory model,
// expected loads queued at issue and checked when read_data updates.
module tb_data_mem_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, write_data;
    logic        memwrite, memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic [7:0]  led;
    logic        clk_stall, misaligned;

    localparam logic [31:0] LED_A = 32'h2000;
    localparam logic [3:0] SB = 4'b1001, BU = 4'b0001;
    localparam logic [3:0] SH = 4'b1011, SW = 4'b1111;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_m [1024];
    logic [7:0]  led_m;
    logic [31:0] saved;

    data_mem_sb dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
        .read_data(read_data), .led(led), .clk_stall(clk_stall),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic is_mis(input logic [31:0] a, input logic [3:0] sm);
        return (sm[2:0] == 3'b011 && a[0]) ||
               (sm[2:0] == 3'b111 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [3:0] sm);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        logic        sx;
        w  = (a == LED_A) ? {24'h0, led_m} : mem_m[a[11:2]];
        sx = sm[3] && (a != LED_A);
        b  = w[8*a[1:0] +: 8];
        h  = w[16*a[1] +: 16];
        if (sm[2:0] == 3'b001) return {{24{sx & b[7]}}, b};
        if (sm[2:0] == 3'b011) return {{16{sx & h[15]}}, h};
        return w;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sm);
        if (a == LED_A)             led_m = d[7:0];
        else if (sm[2:0] == 3'b001) mem_m[a[11:2]][8*a[1:0] +: 8] = d[7:0];
        else if (sm[2:0] == 3'b011) mem_m[a[11:2]][16*a[1] +: 16] = d[15:0];
        else                        mem_m[a[11:2]] = d;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sm,
                      input logic exp_stall);
        logic m;
        memread = rd; memwrite = wr; addr = a; write_data = d; sign_mask = sm;
        #1;
        chk("stall", {31'h0, clk_stall}, {31'h0, exp_stall});
        if (exp_stall) begin
            @(posedge clk); #1;
            chk("stall_clr", {31'h0, clk_stall}, 32'h0);
        end
        m = (rd | wr) & is_mis(a, sm);
        if (rd) exp_q.push_back(m ? 32'h0 : m_load(a, sm));
        if (wr && !m) m_store(a, d, sm);
        @(posedge clk); #1;
        if (rd) chk("load", read_data, exp_q.pop_front());
        chk("mis", {31'h0, misaligned}, {31'h0, m});
        chk("led", {24'h0, led}, {24'h0, led_m});
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 32'h0, 32'h0, SW, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        led_m = 8'h0;
        chk("rst_rd", read_data, 32'h0);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        chk("rst_stall", {31'h0, clk_stall}, 32'h0);
        chk("rst_sbv", {31'h0, dut.sb_valid}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
        led_m = 8'h0;
        addr = 0; write_data = 0; sign_mask = SW;
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0;
        @(posedge clk); #1;
        do_reset();

        op(0, 1, 32'h10, 32'hDEADBEEF, SW, 0);
        idle();
        op(1, 0, 32'h10, 32'h0, SW, 0);

        op(0, 1, 32'h13, 32'h80, SB, 0);
        op(1, 0, 32'h13, 32'h0, SB, 0);
        op(1, 0, 32'h13, 32'h0, BU, 0);
        op(1, 0, 32'h10, 32'h0, SW, 0);
        op(1, 0, 32'h12, 32'h0, SH, 0);

        op(0, 1, 32'h20, 32'h11223344, SW, 0);
        op(1, 0, 32'h20, 32'h0, SW, 0);
        op(1, 0, 32'h10, 32'h0, SW, 0);
        op(1, 0, 32'h21, 32'h0, BU, 0);
        chk("sbv_full", {31'h0, dut.sb_valid}, 32'h1);
        idle();
        chk("hold", read_data, 32'h00000033);
        chk("sbv_drained", {31'h0, dut.sb_valid}, 32'h0);
        op(1, 0, 32'h20, 32'h0, SW, 0);

        op(0, 1, 32'h24, 32'h55667788, SW, 0);
        op(1, 1, 32'h24, 32'hAABBCCDD, SW, 1);
        op(1, 0, 32'h24, 32'h0, SW, 0);
        op(1, 0, 32'h26, 32'h0, SH, 0);

        op(1, 0, 32'h11, 32'h0, SH, 0);
        op(0, 1, 32'h22, 32'hCAFEF00D, SW, 0);
        idle();
        op(1, 0, 32'h10, 32'h0, SW, 0);
        op(1, 0, 32'h20, 32'h0, SW, 0);

        op(0, 1, LED_A, 32'h000000A5, SW, 0);
        op(1, 0, LED_A, 32'h0, BU, 0);
        op(1, 0, LED_A, 32'h0, SB, 0);
        op(1, 0, LED_A, 32'h0, SW, 0);
        op(0, 1, 32'h30, 32'h00000055, SW, 0);
        idle();
        saved = mem_m[12];
        op(0, 1, 32'h30, 32'h77777777, SW, 0);
        do_reset();
        mem_m[12] = saved;
        op(1, 0, 32'h30, 32'h0, SW, 0);
        op(1, 0, 32'h24, 32'h0, SW, 0);

        chk("q_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
